// File: rtl/uart_tx_byte_queue.sv
// uart_tx_byte_queue: byte queue feeding the dynamic-baud UART transmitter.
// Host bytes are buffered and launched one at a time over the
// tx_start/tx_data/tx_busy handshake. If the transmitter never acknowledges
// a launch, the byte is dropped and tx_err pulses.
// Optional build macro: UART_TXQ_OVF_FLAG_EN adds ovf_clr/ovf, a sticky flag
// for writes dropped while the queue is full.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for a queued byte and an idle transmitter
// LAUNCH    | tx_start high for this single cycle, ack timer being loaded
// WAIT_BUSY | waiting for tx_busy to rise; ack timer counting down
// WAIT_DONE | transmitter busy with the byte; waiting for tx_busy to fall
`timescale 1ns/1ps

module uart_tx_byte_queue #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              tx_err
`ifdef UART_TXQ_OVF_FLAG_EN
    ,
    input  logic              ovf_clr,
    output logic              ovf
`endif
);

    localparam int TMR_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    // The ack timer counts down from ACK_TIMEOUT-1; expiry is the cycle it
    // is already at zero, so WAIT_BUSY lasts exactly ACK_TIMEOUT cycles.
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [TMR_W-1:0]   tmr_q;
    logic [TMR_W-1:0]   tmr_d;
    logic               tx_start_q;
    logic               tx_start_d;
    logic               tx_err_q;
    logic               tx_err_d;
    logic               pop;
    logic               push;

    logic [7:0]         mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W:0]    count_q;
    logic [7:0]         tx_data_q;

    // Status flags come straight from the registered count, so wr_en has no
    // combinational path to full/empty/count.
    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign tx_err   = tx_err_q;

    // A write while full is dropped even if a pop frees a slot on that edge.
    assign push = wr_en && !full;

    // Next-state and next-output logic for the launch/acknowledge sequence.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        tx_start_d = 1'b0;
        tx_err_d   = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                tmr_d   = TMR_LAST;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmr_q == '0) begin
                    // No acknowledge: the byte is lost, not retried.
                    tx_err_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, ack timer and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            tx_start_q <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            tx_start_q <= tx_start_d;
            tx_err_q   <= tx_err_d;
        end
    end

    // Queue pointers, occupancy and the launched byte held for the transmitter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            tx_data_q <= 8'h00;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + ADDR_W'(1);
                tx_data_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (ADDR_W + 1)'(1);
                2'b01:   count_q <= count_q - (ADDR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Byte storage; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

`ifdef UART_TXQ_OVF_FLAG_EN
    // Sticky overflow flag; a new drop takes priority over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (wr_en && full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_byte_queue.sv
// Bench for uart_tx_byte_queue: transmitter model plus a queue-level
// reference model of accepted bytes, launch order, occupancy and timing.
`timescale 1ns/1ps

module tb_uart_tx_byte_queue;

    localparam int DEPTH       = 16;
    localparam int ADDR_W      = 4;
    localparam int ACK_TIMEOUT = 8;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              wr_en   = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy = 1'b0;
    logic              tx_err;
`ifdef UART_TXQ_OVF_FLAG_EN
    logic              ovf_clr = 1'b0;
    logic              ovf;
    bit                ovf_m   = 1'b0;
`endif

    int                total = 0;
    int                bad   = 0;

    logic [7:0]        q[$];
    logic [7:0]        sent[$];
    logic [7:0]        last_data = 8'h00;
    bit                prev_start = 1'b0;
    int                run = 0;

    int unsigned       busy_n = 3;
    bit                ignore_start = 1'b0;
    bit                hold_busy = 1'b0;
    int unsigned       rem = 0;

    uart_tx_byte_queue #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .tx_err(tx_err)
`ifdef UART_TXQ_OVF_FLAG_EN
        , .ovf_clr(ovf_clr), .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    // Transmitter model: busy rises the cycle after tx_start, stays busy_n cycles.
    always @(posedge clk) begin
        if (tx_start && !ignore_start) begin
            tx_busy <= 1'b1;
            rem     <= busy_n - 1;
        end else if (rem > 0) begin
            rem <= rem - 1;
        end else begin
            tx_busy <= hold_busy;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus, then the reference model is advanced and compared.
    task automatic step(input bit w, input logic [7:0] d);
        bit         accept;
        logic [7:0] e;
`ifdef UART_TXQ_OVF_FLAG_EN
        bit         ovf_set;
        bit         clr;
        ovf_set = w && (q.size() == DEPTH);
        clr     = ovf_clr;
`endif
        wr_en   = w;
        wr_data = d;
        accept  = w && (q.size() < DEPTH);
        @(posedge clk);
        #1;
        if (q.size() == 0) chk("launch_when_empty", 32'(tx_start), 0);
        if (tx_start === 1'b1 && q.size() > 0) begin
            e = q.pop_front();
            sent.push_back(e);
            chk("tx_data_at_launch", 32'(tx_data), 32'(e));
            chk("busy_at_launch", 32'(tx_busy), 0);
            chk("start_one_cycle", 32'(prev_start), 0);
            last_data = e;
        end else begin
            chk("tx_data_hold", 32'(tx_data), 32'(last_data));
        end
        if (accept) q.push_back(d);
        chk("count", 32'(count), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        if (!ignore_start) begin
            chk("no_tx_err", 32'(tx_err), 0);
            if (q.size() > 0 && tx_busy === 1'b0 && tx_start === 1'b0) run++;
            else run = 0;
            chk("launch_gap_ok", 32'(run <= 2), 1);
        end
        prev_start = tx_start;
`ifdef UART_TXQ_OVF_FLAG_EN
        if (ovf_set) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        chk("ovf", 32'(ovf), 32'(ovf_m));
`endif
    endtask

    task automatic drain(input int max);
        int quiet = 0;
        bit done  = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            step(1'b0, 8'h00);
            if (q.size() == 0 && tx_busy === 1'b0 && tx_start === 1'b0) quiet++;
            else quiet = 0;
            if (quiet >= ACK_TIMEOUT + 4) done = 1'b1;
        end
        chk("drain_within_budget", 32'(done), 1);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        wr_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_tx_err", 32'(tx_err), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
`ifdef UART_TXQ_OVF_FLAG_EN
        chk("rst_ovf", 32'(ovf), 0);
        ovf_m = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        last_data  = 8'h00;
        prev_start = 1'b0;
        run        = 0;
    endtask

    initial begin
        bit found;

        // Reset and a single byte with its launch latency.
        do_reset();
        step(1'b1, 8'hA5);
        chk("t1_no_start_yet", 32'(tx_start), 0);
        chk("t1_count_after_write", 32'(count), 1);
        step(1'b0, 8'h00);
        chk("t1_start", 32'(tx_start), 1);
        chk("t1_data", 32'(tx_data), 32'h0A5);
        chk("t1_empty_after_pop", 32'(empty), 1);
        chk("t1_count_after_pop", 32'(count), 0);
        drain(60);

        // Fill the queue while the transmitter is held busy, overflow it, then drain.
        busy_n    = 20;
        hold_busy = 1'b1;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        sent.delete();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i));
        chk("t2_full", 32'(full), 1);
        chk("t2_count16", 32'(count), 16);
        step(1'b1, 8'hFF);
        chk("t3_count_stays16", 32'(count), 16);
        chk("t3_still_full", 32'(full), 1);
`ifdef UART_TXQ_OVF_FLAG_EN
        step(1'b0, 8'h00);
        chk("t3_ovf_sticky", 32'(ovf), 1);
        ovf_clr = 1'b1;
        step(1'b0, 8'h00);
        ovf_clr = 1'b0;
        chk("t3_ovf_cleared", 32'(ovf), 0);
`endif
        hold_busy = 1'b0;
        drain(DEPTH * 30 + 50);
        chk("t2_pulse_count", 32'(sent.size()), 16);
        for (int i = 0; i < DEPTH; i++) begin
            if (i < sent.size()) chk("t2_order", 32'(sent[i]), 32'(i));
        end

        // Transmitter ignores the launch: ack timeout, byte dropped, next launched.
        busy_n       = 3;
        ignore_start = 1'b1;
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        chk("t4_first_launch", 32'(tx_start), 1);
        for (int i = 0; i < ACK_TIMEOUT; i++) begin
            step(1'b0, 8'h00);
            chk("t4_err_not_yet", 32'(tx_err), 0);
        end
        step(1'b0, 8'h00);
        chk("t4_err_pulse", 32'(tx_err), 1);
        step(1'b0, 8'h00);
        chk("t4_err_one_cycle", 32'(tx_err), 0);
        chk("t4_next_launch", 32'(tx_start), 1);
        chk("t4_next_data", 32'(tx_data), 32'h022);
        drain(60);
        ignore_start = 1'b0;
        drain(20);

        // Write coinciding with a launch while three bytes are queued.
        busy_n = 20;
        step(1'b1, 8'h31);
        step(1'b1, 8'h32);
        step(1'b1, 8'h33);
        step(1'b1, 8'h34);
        chk("t5_count3", 32'(count), 3);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, 8'h00);
            if (tx_busy === 1'b0) found = 1'b1;
        end
        chk("t5_busy_fell", 32'(found), 1);
        step(1'b0, 8'h00);
        chk("t5_idle_gap", 32'(tx_start), 0);
        step(1'b1, 8'h35);
        chk("t5_launch", 32'(tx_start), 1);
        chk("t5_count_unchanged", 32'(count), 3);
        drain(200);

        // Reset while the transmitter is busy with five bytes queued.
        busy_n = 20;
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h41 + i));
        chk("t6_count5", 32'(count), 5);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 8'h00);
            chk("t6_no_launch", 32'(tx_start), 0);
        end
        sent.delete();
        step(1'b1, 8'h55);
        drain(80);
        chk("t6_new_byte_sent", 32'(sent.size()), 1);
        if (sent.size() > 0) chk("t6_new_byte_value", 32'(sent[0]), 32'h055);

        // Random traffic with varying transmitter busy time.
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) busy_n = $urandom_range(1, 8);
`ifdef UART_TXQ_OVF_FLAG_EN
            ovf_clr = ($urandom_range(0, 9) == 0);
`endif
            step($urandom_range(0, 99) < 45, 8'($urandom));
        end
`ifdef UART_TXQ_OVF_FLAG_EN
        ovf_clr = 1'b0;
`endif
        drain(DEPTH * 15 + 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
